fan_ramp_ctrl: RTL and testbench

- Closed-loop speed controller that drives the 8-bit speed (duty-cycle) input of the FanSpeed PWM generator in the smart-home system.
- Converts temperature samples, or a manual override, into a target speed.
- Sequences the fan toward that target: full-power kick-start from standstill, then rate-limited stepping, with no abrupt duty jumps.

---
 rtl/fan_ctrl_pkg.sv | 27 ++
 rtl/fan_temp_map.sv | 44 ++++
 rtl/fan_ramp_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_fan_ramp_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fan_ctrl_pkg
//  Description : Shared definitions for the fan speed controller family.
//                Holds the FSM state encoding, the speed width, and a
//                16-to-8-bit saturating helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fan_ctrl_pkg;

    localparam int SPEED_W = 8;

    // Encoding is visible on the state output port and must not change.
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_KICK = 2'd1,
        ST_RAMP = 2'd2,
        ST_HOLD = 2'd3
    } fan_state_e;

    // Clamp a 16-bit unsigned value into the 8-bit speed range.
    function automatic logic [SPEED_W-1:0] sat8(input logic [15:0] value);
        return (value > 16'd255) ? 8'hFF : value[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fan_temp_map.sv
`default_nettype none
// ============================================================================
//  Module      : fan_temp_map
//  Description : Combinational temperature -> target speed mapping.
//                At or below T_LOW the target is 0.  Above T_LOW the target
//                is (temp - T_LOW) * SLOPE, saturated to 255, with any
//                non-zero result below MIN_SPEED raised to MIN_SPEED.
//  Ports       : temp   in  [7:0]  temperature, unsigned degC
//                target out [7:0]  mapped target speed
//  Revision    : 1.0 - initial release
// ============================================================================
module fan_temp_map
    import fan_ctrl_pkg::*;
#(
    parameter int T_LOW     = 25,
    parameter int SLOPE     = 16,
    parameter int MIN_SPEED = 64
) (
    input  logic [SPEED_W-1:0] temp,
    output logic [SPEED_W-1:0] target
);

    logic [15:0]        w_excess;
    logic [15:0]        w_product;
    logic [SPEED_W-1:0] w_sat;

    always_comb begin
        // w_excess is only meaningful when temp > T_LOW; the wrap otherwise
        // is masked by the first branch below.
        w_excess  = 16'(temp) - 16'(T_LOW);
        w_product = w_excess * 16'(SLOPE);
        w_sat     = sat8(w_product);

        if (temp <= SPEED_W'(T_LOW)) begin
            target = '0;
        end else if ((w_sat != '0) && (w_sat < SPEED_W'(MIN_SPEED))) begin
            target = SPEED_W'(MIN_SPEED);
        end else begin
            target = w_sat;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fan_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fan_ramp_ctrl
//  Description : Closed-loop fan speed sequencer feeding the PWM generator.
//                Target comes from the temperature map or a manual override.
//                From standstill the fan is kicked at KICK_SPEED for
//                KICK_TICKS cycles, then speed steps by STEP every
//                STEP_TICKS cycles toward the target without overshoot.
//  Ports       : clk          in       clock, rising edge
//                arst         in       asynchronous active-high reset
//                temp         in [7:0] temperature sample, unsigned degC
//                temp_valid   in       one-cycle strobe qualifying temp
//                manual_en    in       manual override enable (level)
//                manual_speed in [7:0] override target speed
//                speed        out[7:0] registered speed to PWM
//                target       out[7:0] registered current target
//                at_target    out      speed == target
//                fan_on       out      state != OFF
//                state        out[1:0] OFF=0 KICK=1 RAMP=2 HOLD=3
//  Revision    : 1.0 - initial release
// ============================================================================
module fan_ramp_ctrl
    import fan_ctrl_pkg::*;
#(
    parameter int T_LOW      = 25,
    parameter int SLOPE      = 16,
    parameter int MIN_SPEED  = 64,
    parameter int KICK_SPEED = 255,
    parameter int KICK_TICKS = 5000,
    parameter int STEP       = 16,
    parameter int STEP_TICKS = 1000
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [SPEED_W-1:0] temp,
    input  logic               temp_valid,
    input  logic               manual_en,
    input  logic [SPEED_W-1:0] manual_speed,
    output logic [SPEED_W-1:0] speed,
    output logic [SPEED_W-1:0] target,
    output logic               at_target,
    output logic               fan_on,
    output logic [1:0]         state
);

    // One counter serves both the kick timer and the step timer.
    localparam int CNT_MAX = (KICK_TICKS > STEP_TICKS) ? KICK_TICKS : STEP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   c_KICK_LAST = CNT_W'(KICK_TICKS - 1);
    localparam logic [CNT_W-1:0]   c_STEP_LAST = CNT_W'(STEP_TICKS - 1);
    localparam logic [SPEED_W-1:0] c_KICK_VAL  = SPEED_W'(KICK_SPEED);
    localparam logic [SPEED_W-1:0] c_MIN_VAL   = SPEED_W'(MIN_SPEED);
    localparam logic [SPEED_W:0]   c_STEP_VAL  = (SPEED_W + 1)'(STEP);

    fan_state_e         r_state;
    fan_state_e         w_state_nxt;
    logic [SPEED_W-1:0] r_speed;
    logic [SPEED_W-1:0] w_speed_nxt;
    logic [SPEED_W-1:0] r_target;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;

    logic [SPEED_W-1:0] w_map_target;
    logic [SPEED_W-1:0] w_manual_target;
    logic [SPEED_W:0]   w_up_sum;
    logic [SPEED_W-1:0] w_up_speed;
    logic [SPEED_W-1:0] w_dn_speed;
    logic [SPEED_W-1:0] w_step_speed;

    // ------------------------------------------------------------------
    // Target selection
    // ------------------------------------------------------------------
    fan_temp_map #(
        .T_LOW     (T_LOW),
        .SLOPE     (SLOPE),
        .MIN_SPEED (MIN_SPEED)
    ) u_temp_map (
        .temp   (temp),
        .target (w_map_target)
    );

    always_comb begin
        w_manual_target = manual_speed;
        if ((manual_speed != '0) && (manual_speed < c_MIN_VAL)) begin
            w_manual_target = c_MIN_VAL;
        end
    end

    // Manual override wins over temperature; once override drops, the last
    // manual value is retained until a fresh temperature sample arrives.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_target <= '0;
        end else if (manual_en) begin
            r_target <= w_manual_target;
        end else if (temp_valid) begin
            r_target <= w_map_target;
        end
    end

    // ------------------------------------------------------------------
    // Step arithmetic: 9-bit so that neither direction can wrap; each
    // direction clips at the target so a step never overshoots.
    // ------------------------------------------------------------------
    always_comb begin
        w_up_sum   = {1'b0, r_speed} + c_STEP_VAL;
        w_up_speed = (w_up_sum > {1'b0, r_target}) ? r_target : w_up_sum[SPEED_W-1:0];

        if ({1'b0, r_speed} < ({1'b0, r_target} + c_STEP_VAL)) begin
            w_dn_speed = r_target;
        end else begin
            w_dn_speed = r_speed - c_STEP_VAL[SPEED_W-1:0];
        end

        w_step_speed = (r_speed < r_target) ? w_up_speed : w_dn_speed;
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_OFF;
            r_speed <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_speed <= w_speed_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_speed_nxt = r_speed;
        w_count_nxt = r_count;

        case (r_state)
            ST_OFF: begin
                w_speed_nxt = '0;
                if (r_target != '0) begin
                    w_state_nxt = ST_KICK;
                    w_speed_nxt = c_KICK_VAL;
                    w_count_nxt = '0;
                end
            end

            ST_KICK: begin
                if (r_target == '0) begin
                    w_state_nxt = ST_OFF;
                    w_speed_nxt = '0;
                end else if (r_count == c_KICK_LAST) begin
                    w_state_nxt = ST_RAMP;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end

            ST_RAMP: begin
                // Arrival is checked before stepping so a settled speed is
                // never disturbed by a pending step.
                if (r_speed == r_target) begin
                    w_state_nxt = (r_target == '0) ? ST_OFF : ST_HOLD;
                end else if (r_count == c_STEP_LAST) begin
                    w_count_nxt = '0;
                    w_speed_nxt = w_step_speed;
                end else begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (r_target != r_speed) begin
                    w_state_nxt = ST_RAMP;
                    w_count_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = ST_OFF;
                w_speed_nxt = '0;
                w_count_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign speed     = r_speed;
    assign target    = r_target;
    assign state     = r_state;
    assign at_target = (r_speed == r_target);
    assign fan_on    = (r_state != ST_OFF);

endmodule
`default_nettype wire

// File: tb/tb_fan_ramp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fan_ramp_ctrl
//  Description : Self-checking bench for fan_ramp_ctrl with short kick/step
//                timers.  A behavioural model of the sequencing rules runs
//                alongside the design; directed scenarios are followed by a
//                randomized stimulus phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fan_ramp_ctrl;

    localparam int TB_KICK_TICKS = 8;
    localparam int TB_STEP_TICKS = 4;

    logic       clk;
    logic       arst;
    logic [7:0] temp;
    logic       temp_valid;
    logic       manual_en;
    logic [7:0] manual_speed;
    logic [7:0] speed;
    logic [7:0] target;
    logic       at_target;
    logic       fan_on;
    logic [1:0] state;

    int n_checks = 0;
    int n_err    = 0;

    fan_ramp_ctrl #(
        .KICK_TICKS (TB_KICK_TICKS),
        .STEP_TICKS (TB_STEP_TICKS)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .temp         (temp),
        .temp_valid   (temp_valid),
        .manual_en    (manual_en),
        .manual_speed (manual_speed),
        .speed        (speed),
        .target       (target),
        .at_target    (at_target),
        .fan_on       (fan_on),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        int st;
        int spd;
        int cnt;
    } mdl_t;

    mdl_t m        = '0;
    int   m_target = 0;

    function automatic int map_temp(int t);
        int p;
        if (t <= 25) return 0;
        p = (t - 25) * 16;
        if (p > 255) p = 255;
        if (p < 64)  p = 64;
        return p;
    endfunction

    function automatic int man_clamp(int v);
        if (v == 0) return 0;
        return (v < 64) ? 64 : v;
    endfunction

    function automatic mdl_t model_next(mdl_t c, int tgt);
        mdl_t n;
        n = c;
        case (c.st)
            0: begin
                n.spd = 0;
                if (tgt != 0) begin
                    n.st = 1; n.spd = 255; n.cnt = 0;
                end
            end
            1: begin
                if (tgt == 0) begin
                    n.st = 0; n.spd = 0;
                end else if (c.cnt + 1 == TB_KICK_TICKS) begin
                    n.st = 2; n.cnt = 0;
                end else begin
                    n.cnt = c.cnt + 1;
                end
            end
            2: begin
                if (c.spd == tgt) begin
                    n.st = (tgt == 0) ? 0 : 3;
                end else if (c.cnt + 1 == TB_STEP_TICKS) begin
                    n.cnt = 0;
                    if (c.spd < tgt) n.spd = (c.spd + 16 > tgt) ? tgt : c.spd + 16;
                    else             n.spd = (c.spd - 16 < tgt) ? tgt : c.spd - 16;
                end else begin
                    n.cnt = c.cnt + 1;
                end
            end
            3: begin
                if (tgt != c.spd) begin
                    n.st = 2; n.cnt = 0;
                end
            end
            default: n = '0;
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m        <= '0;
            m_target <= 0;
        end else begin
            m <= model_next(m, m_target);
            if (manual_en)       m_target <= man_clamp(int'(manual_speed));
            else if (temp_valid) m_target <= map_temp(int'(temp));
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("speed",     speed,     m.spd);
        chk("target",    target,    m_target);
        chk("state",     state,     m.st);
        chk("at_target", at_target, (m.spd == m_target) ? 1 : 0);
        chk("fan_on",    fan_on,    (m.st != 0) ? 1 : 0);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic strobe(input int t);
        temp       = 8'(t);
        temp_valid = 1'b1;
        tick();
        temp_valid = 1'b0;
    endtask

    task automatic wait_state(input int st, input int budget, input string tag);
        int k;
        k = 0;
        while ((state != 2'(st)) && (k < budget)) begin
            tick();
            k++;
        end
        chk(tag, state, st);
    endtask

    // Assert reset between clock edges and verify it acts without a clock.
    task automatic async_reset();
        #2 arst = 1'b1;
        #1;
        chk("rst_speed",     speed,     0);
        chk("rst_target",    target,    0);
        chk("rst_state",     state,     0);
        chk("rst_at_target", at_target, 1);
        chk("rst_fan_on",    fan_on,    0);
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int k;
        int idx;
        int prev;
        int exp_dn[5];

        exp_dn       = '{64, 48, 32, 16, 0};
        arst         = 1'b1;
        temp         = '0;
        temp_valid   = 1'b0;
        manual_en    = 1'b0;
        manual_speed = '0;

        repeat (2) @(negedge clk);
        chk("init_speed",     speed,     0);
        chk("init_state",     state,     0);
        chk("init_at_target", at_target, 1);
        chk("init_fan_on",    fan_on,    0);
        arst = 1'b0;
        repeat (3) tick();

        // Cold start, interrupted by reset mid-ramp at speed 143
        strobe(30);
        chk("cold_target", target, 80);
        k = 0;
        while ((speed != 8'd143) && (k < 200)) begin
            tick();
            k++;
        end
        chk("pre_rst_speed", speed, 143);
        async_reset();
        repeat (4) tick();
        chk("post_rst_state", state, 0);

        // Full cold start
        strobe(30);
        chk("cold_target2", target, 80);
        tick();
        chk("kick_state", state, 1);
        chk("kick_speed", speed, 255);
        k = 0;
        while ((state == 2'd1) && (k < 50)) begin
            k++;
            tick();
        end
        chk("kick_len", k, TB_KICK_TICKS);
        wait_state(3, 200, "cold_hold");
        chk("cold_hold_speed", speed, 80);
        chk("cold_at_target",  at_target, 1);

        // Ramp down to stop
        strobe(20);
        idx  = 0;
        prev = int'(speed);
        k    = 0;
        while ((state != 2'd0) && (k < 100)) begin
            tick();
            k++;
            if (int'(speed) != prev && idx < 5) begin
                chk("down_step", speed, exp_dn[idx]);
                idx++;
                prev = int'(speed);
            end
        end
        chk("down_steps", idx, 5);
        chk("down_off",   fan_on, 0);

        // Mapping edges
        strobe(25);
        repeat (3) tick();
        chk("map25_target", target, 0);
        chk("map25_state",  state, 0);
        strobe(26);
        chk("map26_target", target, 64);
        wait_state(3, 200, "map26_hold");
        chk("map26_speed", speed, 64);
        strobe(20);
        wait_state(0, 200, "map_off");
        strobe(50);
        chk("map50_target", target, 255);
        wait_state(2, 50, "map50_ramp");
        tick();
        chk("map50_hold",  state, 3);
        chk("map50_speed", speed, 255);

        // Manual override
        manual_en    = 1'b1;
        manual_speed = 8'd10;
        strobe(50);
        chk("man_target", target, 64);
        repeat (3) strobe(50);
        chk("man_ignore_temp", target, 64);
        manual_en = 1'b0;
        repeat (5) tick();
        chk("man_retain", target, 64);
        strobe(30);
        chk("man_release", target, 80);

        // Abort during kick
        strobe(20);
        wait_state(0, 300, "abort_pre_off");
        strobe(40);
        tick();
        chk("abort_in_kick", state, 1);
        strobe(20);
        tick();
        chk("abort_state", state, 0);
        chk("abort_speed", speed, 0);

        // Reversal mid-ramp
        manual_en    = 1'b1;
        manual_speed = 8'd200;
        tick();
        wait_state(3, 200, "rev_hold");
        chk("rev_hold_speed", speed, 200);
        manual_speed = 8'd80;
        repeat (2) tick();
        chk("rev_ramp", state, 2);
        manual_speed = 8'd240;
        k = 0;
        while ((speed == 8'd200) && (k < 20)) begin
            tick();
            k++;
        end
        chk("rev_step", speed, 216);
        manual_en = 1'b0;

        // Randomized phase
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 79) == 0) manual_en = ~manual_en;
            if ($urandom_range(0, 9) == 0)  manual_speed = 8'($urandom_range(0, 255));
            temp       = 8'($urandom_range(15, 45));
            temp_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                async_reset();
            end else begin
                tick();
            end
        end
        temp_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
